// File: rtl/uart_rx_sampler.sv
// 8N1 UART receiver: synchronises rxd, validates the start bit at mid-bit,
// samples LSB-first data at bit centres and strobes good bytes or frame errors.
module uart_rx_sampler #(
    parameter int CLKS_PER_BIT = 868,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rdata,
    output logic       rvalid,
    output logic       frame_err,
    output logic       busy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                 state;
    state_t                 state_nx;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_nx;
    logic [2:0]             bitn;
    logic [2:0]             bitn_nx;
    logic [7:0]             shreg;
    logic [7:0]             shreg_nx;
    logic                   at_half;
    logic                   at_full;
    logic                   stop_centre;
    logic                   byte_ok;
    logic                   stop_bad;

    // Synchroniser resets to the idle-high line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
        end
    end

    assign rx_s    = sync_q[SYNC_STAGES-1];
    assign at_half = (cnt == CNT_HALF);
    assign at_full = (cnt == CNT_FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            bitn  <= '0;
            shreg <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            bitn  <= bitn_nx;
            shreg <= shreg_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        bitn_nx  = bitn;
        shreg_nx = shreg;
        unique case (state)
            IDLE: begin
                cnt_nx = '0;
                if (!rx_s) begin
                    state_nx = START;
                end
            end
            START: begin
                if (at_half) begin
                    cnt_nx   = '0;
                    bitn_nx  = '0;
                    state_nx = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (at_full) begin
                    cnt_nx   = '0;
                    shreg_nx = {rx_s, shreg[7:1]};
                    if (bitn == 3'd7) begin
                        state_nx = STOP;
                    end else begin
                        bitn_nx = bitn + 3'd1;
                    end
                end
            end
            STOP: begin
                // Re-arm at the stop-bit centre to catch back-to-back frames.
                if (at_full) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_comb begin
        busy        = (state != IDLE);
        stop_centre = (state == STOP) && at_full;
        byte_ok     = stop_centre && rx_s;
        stop_bad    = stop_centre && !rx_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata     <= '0;
            rvalid    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rvalid    <= byte_ok;
            frame_err <= stop_bad;
            if (byte_ok) begin
                rdata <= shreg;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Randomised frame-level bench for uart_rx_sampler: expected strobes are
// predicted from frame contents and start-edge time, then scoreboarded.
module tb_uart_rx_sampler;

    localparam int CPB = 16;
    localparam int LAT = 2 + CPB / 2 + 9 * CPB;

    logic       clk;
    logic       rst;
    logic       rxd;
    logic [7:0] rdata;
    logic       rvalid;
    logic       frame_err;
    logic       busy;

    typedef struct {
        int         cyc;
        bit         err;
        logic [7:0] d;
    } ev_t;

    ev_t        exp_q[$];
    int         cyc = 0;
    bit         rst_q = 1'b1;
    logic [7:0] mdata = 8'h00;
    int         checks = 0;
    int         errors = 0;
    int         rv_cnt = 0;
    int         fe_cnt = 0;
    int         last_rv_cyc = 0;
    logic [7:0] last_rv_data = 8'h00;
    int         last_edge = 0;

    uart_rx_sampler #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic fail(input string name, input int act, input int req);
        errors++;
        $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) fail(name, act, req);
    endtask

    task automatic chk_win(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) fail(name, act, lo);
    endtask

    // Scoreboard: every strobe must match the oldest predicted frame outcome.
    always @(negedge clk) begin
        if (rst_q) begin
            exp_q.delete();
            mdata = 8'h00;
            chk("rst_rvalid", int'(rvalid), 0);
            chk("rst_frame_err", int'(frame_err), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_rdata", int'(rdata), 0);
        end else begin
            chk("strobe_excl", int'(rvalid && frame_err), 0);
            if (rvalid || frame_err) begin
                if (rvalid) begin
                    rv_cnt++;
                    last_rv_cyc  = cyc;
                    last_rv_data = rdata;
                end
                if (frame_err) fe_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    fail("unexpected_strobe", int'({rvalid, frame_err}), 0);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    chk("strobe_kind", int'(frame_err), int'(e.err));
                    chk_win("strobe_time", cyc, e.cyc - 1, e.cyc + 1);
                    if (rvalid && !e.err) begin
                        chk("strobe_data", int'(rdata), int'(e.d));
                        mdata = e.d;
                    end
                end
            end
            if (exp_q.size() > 0 && cyc > exp_q[0].cyc + 1) begin
                checks++;
                fail("missing_strobe", cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            chk("rdata_hold", int'(rdata), int'(mdata));
        end
    end

    task automatic drive(input logic v, input int n);
        rxd = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit ok, input int abort_bit);
        ev_t e;
        last_edge = cyc;
        e.cyc = cyc + LAT;
        e.err = !ok;
        e.d   = d;
        exp_q.push_back(e);
        drive(1'b0, CPB);
        chk("busy_mid", int'(busy), 1);
        for (int i = 0; i < 8; i++) begin
            if (i == abort_bit) begin
                drive(d[i], 6);
                rst = 1'b1;
                rxd = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
                return;
            end
            drive(d[i], CPB);
        end
        // A low stop cell is cut short so the re-armed receiver sees a glitch.
        if (ok) begin
            drive(1'b1, CPB);
        end else begin
            drive(1'b0, 12);
            drive(1'b1, CPB - 12);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int rv0;
        int fe0;
        rst = 1'b1;
        rxd = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i % 50 == 0) begin
                chk("t1_rdata", int'(rdata), 0);
                chk("t1_busy", int'(busy), 0);
            end
        end

        rv0 = rv_cnt;
        send_frame(8'hA5, 1'b1, 8);
        drive(1'b1, 20);
        chk("t2_count", rv_cnt - rv0, 1);
        chk("t2_data", int'(last_rv_data), 8'hA5);
        chk_win("t2_latency", last_rv_cyc - last_edge, 153, 155);

        rv0 = rv_cnt;
        fe0 = fe_cnt;
        send_frame(8'h00, 1'b1, 8);
        send_frame(8'hFF, 1'b1, 8);
        send_frame(8'h55, 1'b1, 8);
        drive(1'b1, 20);
        chk("t3_count", rv_cnt - rv0, 3);
        chk("t3_data", int'(last_rv_data), 8'h55);
        chk("t3_no_ferr", fe_cnt - fe0, 0);

        rv0 = rv_cnt;
        drive(1'b0, 3);
        drive(1'b1, 20);
        chk("t4_busy", int'(busy), 0);
        chk("t4_no_strobe", rv_cnt - rv0, 0);
        send_frame(8'h3C, 1'b1, 8);
        drive(1'b1, 20);
        chk("t4_data", int'(rdata), 8'h3C);

        rv0 = rv_cnt;
        fe0 = fe_cnt;
        send_frame(8'h81, 1'b0, 8);
        drive(1'b1, 20);
        chk("t5_ferr", fe_cnt - fe0, 1);
        chk("t5_no_rvalid", rv_cnt - rv0, 0);
        chk("t5_rdata_kept", int'(rdata), 8'h3C);

        rv0 = rv_cnt;
        send_frame(8'h7E, 1'b1, 4);
        chk("t6_rdata_rst", int'(rdata), 0);
        chk("t6_busy_rst", int'(busy), 0);
        drive(1'b1, 30);
        chk("t6_no_strobe", rv_cnt - rv0, 0);
        send_frame(8'h12, 1'b1, 8);
        drive(1'b1, 20);
        chk("t6_data", int'(rdata), 8'h12);

        for (int n = 0; n < 60; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                drive(1'b0, $urandom_range(1, 4));
                drive(1'b1, CPB + $urandom_range(0, 8));
            end else if (r == 1) begin
                send_frame(8'($urandom), 1'b0, 8);
                drive(1'b1, CPB + $urandom_range(0, 8));
            end else begin
                send_frame(8'($urandom), 1'b1, 8);
                drive(1'b1, $urandom_range(0, 5));
            end
        end

        drive(1'b1, 200);
        chk("final_queue_empty", exp_q.size(), 0);
        chk("final_busy", int'(busy), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
